fp_mul_iter: RTL
================

# fp_mul_iter

Parametrised IEEE-754 floating-point multiplier (binary32 or binary64) for the FPU, built around an iterative shift-add mantissa datapath behind valid/ready handshakes on both sides. Each accepted operation yields a correctly rounded (round-to-nearest-even) product, canonical NaN propagation, signed zeros and infinities, and optional exception flags. It sits between the FPU issue logic and the FP result writeback, trading latency for area compared with a single-cycle array multiplier.

## Interface
- BUS_WIDTH, 64 — operand width; 32 or 64 only. MANT = 23/52, EXP = 8/11, BIAS = 127/1023.
- MUL_BITS, 4 — multiplier bits consumed per MUL cycle; must be 1, 2, 4 or 8.
- clk  in  1  clock; everything is clocked on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block idle and able to accept.
- in1, in2  in  BUS_WIDTH  operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  BUS_WIDTH  product.
- flags  out  4  {invalid, overflow, underflow, inexact}, valid with out_valid.

## Operation
- States: IDLE, MUL, ROUND, DONE. Reset enters IDLE. Reset values: in_ready=1, out_valid=0, out=0, flags=0.
- IDLE: in_ready=1. On in_valid, latch sign = S1^S2, the exponent sum, and both significands with the hidden bit (hidden bit = |E). Classify the operands in the same cycle:
  - Either operand NaN, or Inf×0 → out = canonical NaN (0x7FC00000 / 0x7FF8000000000000), sign 0. invalid is set unless an input was already a quiet NaN; a signalling NaN input sets invalid.
  - Inf × finite-nonzero → ±Inf, no flags.
  - Either operand zero or subnormal (flush-to-zero) → ±0, no flags.
  - All special cases go directly to DONE. Other operations go to MUL with counter = 0.
- MUL: shift-add of the (MANT+1)-bit significands, MUL_BITS multiplier bits per cycle, into a 2(MANT+1)-bit accumulator. N = ceil((MANT+1)/MUL_BITS) cycles, then go to ROUND.
- ROUND, one cycle:
  - If product MSB = 1, shift right by 1 and add 1 to the exponent.
  - Take L, G and sticky (OR of all lower bits). Round up iff G & (sticky | L), which is round-to-nearest-even.
  - A significand carry-out renormalises and adds 1 to the exponent.
  - Exponent arithmetic is signed, EXP+2 bits: e = E1 + E2 − BIAS + norm + carry.
  - e ≥ 2^EXP−1 → ±Inf, with overflow and inexact set.
  - e ≤ 0 → ±0 (flush-to-zero), with underflow and inexact set.
  - Otherwise pack {sign, e[EXP−1:0], mantissa}. inexact = G | sticky.
  - Go to DONE.
- DONE: out_valid=1; out and flags are held stable. On out_ready, go to IDLE the next cycle with out_valid=0. in_ready=0 in every state except IDLE, so input is not bypassed during DONE.

## Timing
- Accept at clock edge k (in_valid & in_ready).
- Normal operands: out_valid is high from edge k+N+2. With BUS_WIDTH=64 and MUL_BITS=4, N=14, so out_valid rises at edge k+16.
- Special operands: out_valid is high from edge k+1.
- Throughput: at most one operation per (latency + 1) cycles. in_ready rises the cycle after the output handshake.
- Backpressure: out_valid, out and flags stay constant while out_ready=0, for any duration.
- rst in any state, including mid-MUL or DONE: at the next edge the block is in IDLE with the reset output values. The in-flight operation is discarded and never reported.
- in_valid while in_ready=0 is ignored; the operands are not latched.

## Configuration
- FP_MUL_FLAGS_EN defined: the flags logic is present and behaves as above.
- FP_MUL_FLAGS_EN undefined: the flags port still exists but is tied to 4'b0000, and the G/sticky flag registers are removed. out is bit-identical in both builds.

## Test plan
- BUS_WIDTH=32, MUL_BITS=4: 0x40000000 × 0x40400000 → out 0x40C00000, flags 0000. out_valid rises at edge k+8 (N=6).
- Round-to-even tie: 0x3F800001 × 0x3FC00000 → 0x3FC00002, inexact=1. Non-tie: 0x3F800001 × 0x3F800001 → 0x3F800002, inexact=1.
- Overflow: 0x7F000000 × 0x40000000 → 0x7F800000, flags {0,1,0,1}. Underflow: 0x00800000 × 0x00800000 → 0x00000000, flags {0,0,1,1}.
- Specials, each with out_valid at edge k+1:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1.
  - 0xFF800000 × 0x40000000 → 0xFF800000.
  - 0x80000000 × 0x3F800000 → 0x80000000.
- BUS_WIDTH=64: 0x3FF8000000000000 × 0xC000000000000000 → 0xC008000000000000 at edge k+16. Hold out_ready=0 for 5 cycles: out is stable and in_ready stays 0; in_ready=1 one cycle after the handshake.
- Pulse rst during MUL cycle 3 → next edge in_ready=1 and out_valid=0. A following 2.0×3.0 operation completes correctly, with no stale result emitted.

Source files
------------

// File: rtl/fp_mul_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fp_mul_iter : iterative shift-add IEEE-754 multiplier (binary32/binary64),
//               round-to-nearest-even, flush-to-zero, valid/ready on both sides.
//               Optional macro FP_MUL_FLAGS_EN enables {inv,ovf,unf,inx} flags.
// Rev 1.0
// ============================================================================
module fp_mul_iter #(
  parameter int BUS_WIDTH = 64,
  parameter int MUL_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out,
  output logic [3:0]           flags
);
  localparam int MANT  = (BUS_WIDTH == 32) ? 23 : 52;
  localparam int EXP   = (BUS_WIDTH == 32) ? 8 : 11;
  localparam int BIAS  = (1 << (EXP - 1)) - 1;
  localparam int SW    = MANT + 1;
  localparam int ACC_W = 2 * SW;
  localparam int N     = (SW + MUL_BITS - 1) / MUL_BITS;
  localparam int MP_W  = N * MUL_BITS;
  localparam int EW    = EXP + 2;
  localparam int CNT_W = $clog2(N) + 1;

  localparam logic [EW-1:0]        C_BIAS = EW'(BIAS);
  localparam logic [EW-1:0]        C_EMAX = EW'((1 << EXP) - 1);
  localparam logic [CNT_W-1:0]     C_LAST = CNT_W'(N - 1);
  localparam logic [BUS_WIDTH-1:0] C_QNAN = {1'b0, {EXP{1'b1}}, 1'b1, {(MANT-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [BUS_WIDTH-1:0] out_q, out_d;
  logic                 sign_q, sign_d;
  logic [EW-1:0]        exp_q, exp_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [ACC_W-1:0]     mcand_q, mcand_d;
  logic [MP_W-1:0]      mplier_q, mplier_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]           flags_q, flags_d;
`endif

  logic [EXP-1:0]  w_e1, w_e2;
  logic [MANT-1:0] w_m1, w_m2;
  logic            w_zero1, w_zero2, w_inf1, w_inf2, w_nan1, w_nan2;
  logic            w_sign, w_nan_case;

  assign w_e1       = in1[BUS_WIDTH-2:MANT];
  assign w_e2       = in2[BUS_WIDTH-2:MANT];
  assign w_m1       = in1[MANT-1:0];
  assign w_m2       = in2[MANT-1:0];
  assign w_zero1    = (w_e1 == '0);
  assign w_zero2    = (w_e2 == '0);
  assign w_inf1     = (&w_e1) & (w_m1 == '0);
  assign w_inf2     = (&w_e2) & (w_m2 == '0);
  assign w_nan1     = (&w_e1) & (w_m1 != '0);
  assign w_nan2     = (&w_e2) & (w_m2 != '0);
  assign w_sign     = in1[BUS_WIDTH-1] ^ in2[BUS_WIDTH-1];
  assign w_nan_case = w_nan1 | w_nan2 | (w_inf1 & w_zero2) | (w_inf2 & w_zero1);

`ifdef FP_MUL_FLAGS_EN
  logic w_invalid;
  // A quiet NaN input propagates silently; signalling NaN or Inf*0 raises invalid.
  assign w_invalid = (w_nan1 & ~w_m1[MANT-1]) | (w_nan2 & ~w_m2[MANT-1]) | ~(w_nan1 | w_nan2);
`endif

  // Rounding datapath on the finished accumulator (product lies in [1,4)).
  logic             w_norm, w_lsb, w_guard, w_sticky, w_up, w_carry, w_ovf, w_unf;
  logic [ACC_W-1:0] w_p;
  logic [SW-1:0]    w_keep;
  logic [SW:0]      w_rnd;
  logic [MANT-1:0]  w_mant;
  logic [EW-1:0]    w_exp;

  assign w_norm   = acc_q[ACC_W-1];
  assign w_p      = w_norm ? acc_q : {acc_q[ACC_W-2:0], 1'b0};
  assign w_keep   = w_p[ACC_W-1:SW];
  assign w_lsb    = w_p[SW];
  assign w_guard  = w_p[SW-1];
  assign w_sticky = |w_p[SW-2:0];
  assign w_up     = w_guard & (w_sticky | w_lsb);
  assign w_rnd    = {1'b0, w_keep} + {{SW{1'b0}}, w_up};
  assign w_carry  = w_rnd[SW];
  assign w_mant   = w_carry ? w_rnd[MANT:1] : w_rnd[MANT-1:0];
  assign w_exp    = exp_q + EW'(w_norm) + EW'(w_carry);
  assign w_ovf    = ~w_exp[EW-1] & (w_exp >= C_EMAX);
  assign w_unf    = w_exp[EW-1] | (w_exp == '0);

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
`ifdef FP_MUL_FLAGS_EN
    flags_d     = flags_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          sign_d     = w_sign;
          exp_d      = {2'b00, w_e1} + {2'b00, w_e2} - C_BIAS;
          acc_d      = '0;
          mcand_d    = ACC_W'({~w_zero1, w_m1});
          mplier_d   = MP_W'({~w_zero2, w_m2});
          cnt_d      = '0;
`ifdef FP_MUL_FLAGS_EN
          flags_d    = {w_nan_case & w_invalid, 3'b000};
`endif
          if (w_nan_case) begin
            out_d       = C_QNAN;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else if (w_inf1 | w_inf2) begin
            out_d       = {w_sign, {EXP{1'b1}}, {MANT{1'b0}}};
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else if (w_zero1 | w_zero2) begin
            out_d       = {w_sign, {(BUS_WIDTH-1){1'b0}}};
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d     = S_MUL;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_q + mcand_q * ACC_W'(mplier_q[MUL_BITS-1:0]);
        mcand_d  = mcand_q << MUL_BITS;
        mplier_d = mplier_q >> MUL_BITS;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (w_ovf) begin
          out_d = {sign_q, {EXP{1'b1}}, {MANT{1'b0}}};
        end else if (w_unf) begin
          out_d = {sign_q, {(BUS_WIDTH-1){1'b0}}};
        end else begin
          out_d = {sign_q, w_exp[EXP-1:0], w_mant};
        end
`ifdef FP_MUL_FLAGS_EN
        flags_d = {1'b0, w_ovf, ~w_ovf & w_unf, w_ovf | w_unf | w_guard | w_sticky};
`endif
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
`ifdef FP_MUL_FLAGS_EN
      flags_q     <= 4'b0000;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
`ifdef FP_MUL_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
`ifdef FP_MUL_FLAGS_EN
  assign flags     = flags_q;
`else
  assign flags     = 4'b0000;
`endif

endmodule

`default_nettype wire
